bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the four 7-segment digit decoders. It accepts an N-bit binary value on a start pulse and, after a fixed latency, presents registered units/tens/hundreds/thousands nibbles with a one-cycle done strobe. It replaces the combinational divide/modulo chain, which is too slow and too large at wider N.

---
 rtl/bin_to_bcd_seq_pkg.sv | 15 +
 rtl/bin_to_bcd_seq_if.sv | 41 ++++
 rtl/bin_to_bcd_seq_add3.sv | 13 +
 rtl/bin_to_bcd_seq.sv | 106 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Imported by the interface, the add-3 cell and the converter top.
package bcd_pkg;

   localparam int BCD_DIGITS = 4;
   localparam int BCD_MAX    = 9999;

   localparam logic [3:0] BCD_NINE = 4'd9;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/result bundle between a requester and the BCD converter.
// The master issues start/bin_in; the slave returns status and digits.
interface bin_to_bcd_seq_if #(
   parameter int N = 10
);

   logic         start;
   logic [N-1:0] bin_in;
   logic         busy;
   logic         done;
   logic         overflow;
   logic [3:0]   uni;
   logic [3:0]   dec;
   logic [3:0]   cen;
   logic [3:0]   mil;

   modport master (
      output start,
      output bin_in,
      input  busy,
      input  done,
      input  overflow,
      input  uni,
      input  dec,
      input  cen,
      input  mil
   );

   modport slave (
      input  start,
      input  bin_in,
      output busy,
      output done,
      output overflow,
      output uni,
      output dec,
      output cen,
      output mil
   );

endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble correction cell: a nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   always_comb begin
      dout = din;
      if (din >= 4'd5) dout = din + 4'd3;
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Result digits are registered and only change on the done pulse.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int N      = 10,
   parameter int DIGITS = BCD_DIGITS
) (
   input  logic           clk,
   input  logic           rst_n,
   bin_to_bcd_seq_if.slave bus
);

   localparam int CW = $clog2(N + 1);
   localparam int SW = 4 * DIGITS;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [N-1:0]  bin_q;
   logic [SW-1:0] scr;
   logic [SW-1:0] adj;
   logic [SW-1:0] scr_nx;
   logic          ovf_q;
   logic          last;
   logic          accept;

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (scr[4*i +: 4]),
         .dout (adj[4*i +: 4])
      );
   end

   // top bit of the corrected scratch falls off; only the saturating
   // overflow path can need it and that is flagged at capture time
   assign scr_nx = SW'({adj, bin_q[N-1]});
   assign last   = (cnt == CW'(1));
   assign accept = (state == IDLE) && bus.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.start) state_nx = SHIFT;
         SHIFT:   if (last)      state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      unique case (state)
         IDLE:    bus.busy = 1'b0;
         SHIFT:   bus.busy = 1'b1;
         default: bus.busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         bin_q        <= '0;
         scr          <= '0;
         ovf_q        <= 1'b0;
         bus.done     <= 1'b0;
         bus.overflow <= 1'b0;
         bus.uni      <= '0;
         bus.dec      <= '0;
         bus.cen      <= '0;
         bus.mil      <= '0;
      end else begin
         bus.done <= 1'b0;
         if (accept) begin
            bin_q <= bus.bin_in;
            scr   <= '0;
            cnt   <= CW'(N);
            ovf_q <= (32'(bus.bin_in) > 32'(BCD_MAX));
         end else if (state == SHIFT) begin
            scr   <= scr_nx;
            bin_q <= bin_q << 1;
            cnt   <= cnt - CW'(1);
            if (last) begin
               bus.done     <= 1'b1;
               bus.overflow <= ovf_q;
               if (ovf_q) begin
                  bus.uni <= BCD_NINE;
                  bus.dec <= BCD_NINE;
                  bus.cen <= BCD_NINE;
                  bus.mil <= BCD_NINE;
               end else begin
                  bus.uni <= scr_nx[3:0];
                  bus.dec <= scr_nx[7:4];
                  bus.cen <= scr_nx[11:8];
                  bus.mil <= scr_nx[15:12];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized bench for the sequential BCD converter,
// covering a 10-bit and a 14-bit instance against an arithmetic model.
module tb_bin_to_bcd_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int total = 0;
   int passed = 0;
   int lat;
   int v;
   bit early;
   bit saw_done;

   always #5 clk = ~clk;

   bin_to_bcd_seq_if #(.N(10)) ia ();
   bin_to_bcd_seq_if #(.N(14)) ib ();

   bin_to_bcd_seq #(.N(10), .DIGITS(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ia)
   );

   bin_to_bcd_seq #(.N(14), .DIGITS(4)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ib)
   );

   // decimal digits by plain arithmetic, saturated at 9999
   function automatic int ref_bcd(int x);
      int s;
      s = (x > 9999) ? 9999 : x;
      return (((s / 1000) % 10) << 12) | (((s / 100) % 10) << 8)
           | (((s / 10) % 10) << 4) | (s % 10);
   endfunction

   function automatic int outv(bit b);
      if (b) return int'({ib.mil, ib.cen, ib.dec, ib.uni});
      return int'({ia.mil, ia.cen, ia.dec, ia.uni});
   endfunction

   task automatic chk(string tag, int obs, int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic convert(input bit b, input int x, input int budget,
                          output int l);
      int prev;
      prev = outv(b);
      if (b) begin ib.start = 1'b1; ib.bin_in = x[13:0]; end
      else   begin ia.start = 1'b1; ia.bin_in = x[9:0];  end
      @(posedge clk);
      @(negedge clk);
      ia.start = 1'b0;
      ib.start = 1'b0;
      chk("busy_after_accept", int'(b ? ib.busy : ia.busy), 1);
      chk("held_during_conv", outv(b), prev);
      l = 0;
      while (l < budget && !(b ? ib.done : ia.done)) begin
         @(negedge clk);
         l++;
      end
   endtask

   initial begin
      ia.start = 1'b0; ia.bin_in = '0;
      ib.start = 1'b0; ib.bin_in = '0;

      // reset, then idle with no start
      repeat (2) @(negedge clk);
      chk("rst_out_a", outv(0), 0);
      chk("rst_busy_a", int'(ia.busy), 0);
      chk("rst_done_a", int'(ia.done), 0);
      chk("rst_ovf_b", int'(ib.overflow), 0);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ia.done || ib.done) saw_done = 1'b1;
      end
      chk("idle_no_done", int'(saw_done), 0);
      chk("idle_out_a", outv(0), 0);

      // 1023 -> 1023, latency 10
      convert(0, 1023, 20, lat);
      chk("lat_1023", lat, 10);
      chk("val_1023", outv(0), 'h1023);
      chk("ovf_1023", int'(ia.overflow), 0);
      chk("busy_at_done", int'(ia.busy), 0);
      @(negedge clk);
      chk("done_one_cycle", int'(ia.done), 0);

      // back-to-back 0 then 999, second start in the done cycle
      convert(0, 0, 20, lat);
      chk("val_0", outv(0), 0);
      ia.start = 1'b1;
      ia.bin_in = 10'd999;
      @(posedge clk);
      @(negedge clk);
      ia.start = 1'b0;
      lat = 1;
      while (lat < 25 && !ia.done) begin
         @(negedge clk);
         lat++;
      end
      chk("b2b_gap", lat, 11);
      chk("val_999", outv(0), 'h0999);

      // start while busy is ignored
      @(negedge clk);
      ia.start = 1'b1;
      ia.bin_in = 10'd512;
      @(posedge clk);
      @(negedge clk);
      ia.start = 1'b0;
      lat = 0;
      early = 1'b0;
      while (lat < 20 && !ia.done) begin
         if (!ia.busy) early = 1'b1;
         if (lat == 2) begin ia.start = 1'b1; ia.bin_in = 10'd7; end
         else ia.start = 1'b0;
         @(negedge clk);
         lat++;
      end
      ia.start = 1'b0;
      chk("ign_busy_early", int'(early), 0);
      chk("ign_lat", lat, 10);
      chk("ign_val", outv(0), 'h0512);
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (ia.done) saw_done = 1'b1;
      end
      chk("ign_no_second", int'(saw_done), 0);

      // reset mid-conversion
      ia.start = 1'b1;
      ia.bin_in = 10'd777;
      @(posedge clk);
      @(negedge clk);
      ia.start = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out", outv(0), 0);
      chk("rst_mid_busy", int'(ia.busy), 0);
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (ia.done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (14) begin
         @(negedge clk);
         if (ia.done) saw_done = 1'b1;
      end
      chk("rst_mid_nodone", int'(saw_done), 0);
      chk("rst_mid_after", outv(0), 0);
      convert(0, 42, 20, lat);
      chk("lat_42", lat, 10);
      chk("val_42", outv(0), 'h0042);

      // 14-bit instance: saturation and the 9999 boundary
      convert(1, 12345, 30, lat);
      chk("lat_12345", lat, 14);
      chk("val_12345", outv(1), 'h9999);
      chk("ovf_12345", int'(ib.overflow), 1);
      convert(1, 9999, 30, lat);
      chk("val_9999", outv(1), 'h9999);
      chk("ovf_9999", int'(ib.overflow), 0);
      convert(1, 10000, 30, lat);
      chk("ovf_10000", int'(ib.overflow), 1);

      // randomized conversions on both widths
      for (int i = 0; i < 20; i++) begin
         v = int'($urandom_range(1023, 0));
         convert(0, v, 20, lat);
         chk("rnd_lat_a", lat, 10);
         chk("rnd_val_a", outv(0), ref_bcd(v));
         v = int'($urandom_range(16383, 0));
         convert(1, v, 30, lat);
         chk("rnd_lat_b", lat, 14);
         chk("rnd_val_b", outv(1), ref_bcd(v));
         chk("rnd_ovf_b", int'(ib.overflow), (v > 9999) ? 1 : 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
